alu_op_sequencer: RTL and testbench

//  Front-end that issues operations to the combinational ripple ALU (ALU #(.n)) and collects its outputs.

---
 rtl/alu_pkg.sv | 19 +
 rtl/settle_timer.sv | 27 ++
 rtl/alu_op_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: command codes and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_SLT  = 3'd2;
    localparam logic [2:0] CMD_XOR  = 3'd3;
    localparam logic [2:0] CMD_NAND = 3'd4;
    localparam logic [2:0] CMD_AND  = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that measures the ALU settle window; done flags terminal count zero.
module settle_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one operation at a time to a combinational ALU, holds operands for a settle window,
// then returns the captured result and flags on a valid/ready response channel.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | ready for a request; operands from last op still driven
//   ST_SETTLE | operands held, settle timer counting down to capture
//   ST_RESP   | captured result presented, waiting for rsp_ready
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_cmd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic [15:0]      op_count,
    output logic [WIDTH-1:0] alu_operandA,
    output logic [WIDTH-1:0] alu_operandB,
    output logic [2:0]       alu_command,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow
);

    localparam int TW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE_CYCLES - 1);

    state_t state, next_state;
    logic   accept, capture, complete, timer_done;

    settle_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (LOAD_VAL),
        .dec      (state == ST_SETTLE),
        .done     (timer_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        complete   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_done) begin
                    capture    = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    complete   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // req_ready is registered so it stays low throughout reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready <= 1'b0;
        end else begin
            req_ready <= (next_state == ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_operandA <= '0;
            alu_operandB <= '0;
            alu_command  <= '0;
        end else if (accept) begin
            alu_operandA <= req_a;
            alu_operandB <= req_b;
            alu_command  <= req_cmd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else if (capture) begin
            rsp_result   <= alu_result;
            rsp_carryout <= alu_carryout;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            op_count  <= 16'd0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
        end else if (complete) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural 32-bit ALU and a reference model of the ALU rules.
module tb_alu_op_sequencer;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_cmd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carryout;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic [15:0] op_count;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [2:0]  alu_command;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_zero;
    logic        alu_overflow;

    int total = 0;
    int bad   = 0;

    alu_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cmd      (req_cmd),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carryout (rsp_carryout),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .op_count     (op_count),
        .alu_operandA (alu_operandA),
        .alu_operandB (alu_operandB),
        .alu_command  (alu_command),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU behaviour: returns {carryout, zero, overflow, result}.
    function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        logic [32:0] sum;
        logic [31:0] r;
        logic        co, ov;
        co = 1'b0;
        ov = 1'b0;
        r  = 32'd0;
        case (c)
            3'd0: begin
                sum = {1'b0, a} + {1'b0, b};
                r = sum[31:0]; co = sum[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = sum[31:0]; co = sum[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = a ^ b;
            3'd4: r = ~(a & b);
            3'd5: r = a & b;
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {co, (r == 32'd0), ov, r};
    endfunction

    always_comb begin
        {alu_carryout, alu_zero, alu_overflow, alu_result} = alu_model(alu_operandA, alu_operandB, alu_command);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // Issues one op and completes its handshake; reports what came back and the accept-to-valid latency.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                         input int hold, output logic [34:0] got, output int lat, output bit ok);
        int waited;
        req_a = a; req_b = b; req_cmd = c; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            step();
            waited++;
        end
        ok = 1'b0; got = '0; lat = 0;
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        step();
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_cmd = 3'($urandom);
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        ok  = rsp_valid;
        got = {rsp_carryout, rsp_zero, rsp_overflow, rsp_result};
        repeat (hold) step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [119:0] outs;
        reset_n = 1'b0;
        #2;
        outs = {req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow,
                op_count, alu_operandA, alu_operandB, alu_command};
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", outs);
        end
        step();
        step();
        reset_n = 1'b1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++; $display("FAIL ready_before_edge got=%b want=0", req_ready);
        end
        step();
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_release got=%b want=1", req_ready);
        end
    endtask

    task automatic test_add();
        logic [34:0] got; int lat; bit ok;
        do_op(32'hFFFF_FFFF, 32'd1, 3'd0, 0, got, lat, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++; $display("FAIL add_timeout got=%b want=1", ok);
        end
        total++;
        if (got !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
            bad++; $display("FAIL add_rsp got=%h want=%h", got, {1'b1, 1'b1, 1'b0, 32'd0});
        end
        total++;
        if (lat !== 4) begin
            bad++; $display("FAIL add_latency got=%0d want=4", lat);
        end
        total++;
        if (op_count !== 16'd1) begin
            bad++; $display("FAIL add_op_count got=%0d want=1", op_count);
        end
    endtask

    task automatic test_sub();
        logic [34:0] got; int lat; bit ok;
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1, got, lat, ok);
        total++;
        if (!ok || got[31:0] !== 32'h8000_0000 || got[32] !== 1'b1 || got[33] !== 1'b0) begin
            bad++; $display("FAIL sub_rsp got=%h ok=%b want result=80000000 ovf=1 zero=0", got, ok);
        end
    endtask

    task automatic test_slt();
        logic [34:0] got; int lat; bit ok;
        do_op(32'hFFFF_FFFF, 32'd0, 3'd2, 0, got, lat, ok);
        total++;
        if (!ok || got[31:0] !== 32'd1 || got[33] !== 1'b0) begin
            bad++; $display("FAIL slt_less got=%h ok=%b want result=1 zero=0", got, ok);
        end
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 2, got, lat, ok);
        total++;
        if (!ok || got[31:0] !== 32'd0 || got[33] !== 1'b1) begin
            bad++; $display("FAIL slt_equal got=%h ok=%b want result=0 zero=1", got, ok);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        logic [34:0] snap, exp_rsp;
        logic [66:0] alu_snap;
        logic [15:0] cnt0;
        int waited;
        a = $urandom; b = $urandom;
        exp_rsp = alu_model(a, b, 3'd3);
        cnt0 = op_count;
        req_a = a; req_b = b; req_cmd = 3'd3; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        waited = 0;
        while (!rsp_valid && waited < 20) begin
            step();
            waited++;
        end
        snap = {rsp_carryout, rsp_zero, rsp_overflow, rsp_result};
        alu_snap = {alu_operandA, alu_operandB, alu_command};
        total++;
        if (!rsp_valid || snap !== exp_rsp) begin
            bad++; $display("FAIL bp_rsp got=%h valid=%b want=%h", snap, rsp_valid, exp_rsp);
        end
        req_valid = 1'b1; req_a = ~a; req_b = ~b; req_cmd = 3'd6;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0
                || {rsp_carryout, rsp_zero, rsp_overflow, rsp_result} !== snap
                || {alu_operandA, alu_operandB, alu_command} !== alu_snap) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d valid=%b ready=%b rsp=%h alu=%h want rsp=%h alu=%h",
                         i, rsp_valid, req_ready, {rsp_carryout, rsp_zero, rsp_overflow, rsp_result},
                         {alu_operandA, alu_operandB, alu_command}, snap, alu_snap);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        total++;
        if (op_count !== cnt0 + 16'd1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release op_count=%0d valid=%b want op_count=%0d valid=0",
                            op_count, rsp_valid, cnt0 + 16'd1);
        end
        step();
        total++;
        if ({rsp_carryout, rsp_zero, rsp_overflow, rsp_result} !== snap || op_count !== cnt0 + 16'd1) begin
            bad++; $display("FAIL bp_after rsp=%h op_count=%0d want rsp=%h op_count=%0d",
                            {rsp_carryout, rsp_zero, rsp_overflow, rsp_result}, op_count, snap, cnt0 + 16'd1);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [119:0] outs;
        logic [34:0] got; int lat; bit ok; int rises;
        req_a = 32'd5; req_b = 32'd7; req_cmd = 3'd0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        outs = {req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow,
                op_count, alu_operandA, alu_operandB, alu_command};
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL midreset_outputs got=%h want=0", outs);
        end
        step();
        reset_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid) rises++;
        end
        total++;
        if (rises !== 0 || op_count !== 16'd0) begin
            bad++; $display("FAIL midreset_discard valid_cycles=%0d op_count=%0d want 0 and 0", rises, op_count);
        end
        do_op(32'hFFFF_FFFF, 32'd0, 3'd5, 0, got, lat, ok);
        total++;
        if (!ok || got[31:0] !== 32'd0 || got[33] !== 1'b1 || lat !== 4) begin
            bad++; $display("FAIL midreset_and got=%h ok=%b lat=%0d want result=0 zero=1 lat=4", got, ok, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] oa[8];
        logic [31:0] ob[8];
        logic [34:0] expq[$];
        logic [34:0] obs, e;
        int acc_t[$];
        int idx, nrsp, cyc;
        bit will_acc, will_rsp;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            oa[i] = $urandom;
            ob[i] = (i == 2) ? oa[i] : $urandom;
        end
        idx = 0; nrsp = 0; cyc = 0;
        req_a = oa[0]; req_b = ob[0]; req_cmd = 3'd0; req_valid = 1'b1;
        rsp_ready = 1'b1;
        while ((idx < 8 || nrsp < idx) && cyc < 200) begin
            will_acc = req_valid && req_ready;
            will_rsp = rsp_valid && rsp_ready;
            obs = {rsp_carryout, rsp_zero, rsp_overflow, rsp_result};
            if (will_acc) begin
                expq.push_back(alu_model(req_a, req_b, req_cmd));
            end
            step();
            cyc++;
            if (will_rsp) begin
                e = (expq.size() > 0) ? expq.pop_front() : 35'h0;
                total++;
                if (obs !== e) begin
                    bad++; $display("FAIL b2b_rsp idx=%0d got=%h want=%h", nrsp, obs, e);
                end
                nrsp++;
            end
            if (will_acc) begin
                acc_t.push_back(cyc);
                idx++;
                if (idx < 8) begin
                    req_a = oa[idx]; req_b = ob[idx]; req_cmd = 3'(idx);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        rsp_ready = 1'b0;
        total++;
        if (nrsp !== 8 || op_count !== 16'd8) begin
            bad++; $display("FAIL b2b_count responses=%0d op_count=%0d want 8 and 8", nrsp, op_count);
        end
        for (int i = 1; i < acc_t.size(); i++) begin
            total++;
            if (acc_t[i] - acc_t[i-1] !== 6) begin
                bad++; $display("FAIL b2b_spacing idx=%0d got=%0d want=6", i, acc_t[i] - acc_t[i-1]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2:0]  c;
        logic [34:0] got, e;
        logic [15:0] cnt0;
        int lat; bit ok;
        for (int i = 0; i < 12; i++) begin
            a = $urandom; b = $urandom; c = 3'($urandom);
            if (i % 4 == 0) b = a;
            e = alu_model(a, b, c);
            cnt0 = op_count;
            do_op(a, b, c, int'($urandom_range(0, 3)), got, lat, ok);
            total++;
            if (!ok || got !== e || lat !== 4 || op_count !== cnt0 + 16'd1) begin
                bad++;
                $display("FAIL rand_op i=%0d cmd=%0d got=%h ok=%b lat=%0d cnt=%0d want=%h lat=4 cnt=%0d",
                         i, c, got, ok, lat, op_count, e, cnt0 + 16'd1);
            end
        end
    endtask

    initial begin
        req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_cmd = '0;
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
